// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - shared opcode and output-store state enumerations for logic_op_pipe
package logic_op_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/logic_op_core.sv
// rtl/logic_op_core.sv - combinational bitwise operator across NUM_IN operand lanes
module logic_op_core
   import logic_op_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] data,
   input  op_e                     op,
   output logic [WIDTH-1:0]        result
);

   logic [WIDTH-1:0] lane0;
   logic [WIDTH-1:0] and_r;
   logic [WIDTH-1:0] or_r;
   logic [WIDTH-1:0] xor_r;

   // fold every lane into AND / OR / XOR reductions; inverted forms derive from these
   always_comb begin
      lane0 = data[WIDTH-1:0];
      and_r = lane0;
      or_r  = lane0;
      xor_r = lane0;
      for (int k = 1; k < NUM_IN; k++) begin
         and_r = and_r & data[k*WIDTH +: WIDTH];
         or_r  = or_r  | data[k*WIDTH +: WIDTH];
         xor_r = xor_r ^ data[k*WIDTH +: WIDTH];
      end
   end

   // pick the reduction (or lane-0 unary) the opcode asks for
   always_comb begin
      result = lane0;
      case (op)
         OP_AND:  result = and_r;
         OP_OR:   result = or_r;
         OP_XOR:  result = xor_r;
         OP_NAND: result = ~and_r;
         OP_NOR:  result = ~or_r;
         OP_XNOR: result = ~xor_r;
         OP_NOT:  result = ~lane0;
         OP_PASS: result = lane0;
         default: result = lane0;
      endcase
   end

endmodule

// File: rtl/logic_op_pipe.sv
// rtl/logic_op_pipe.sv - 1-cycle logic operator with 2-entry in-order output store; LOGIC_OP_PIPE_REDUCE_EN adds reduce_out
module logic_op_pipe
   import logic_op_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_IN*WIDTH-1:0]  in_data,
   input  logic [2:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [2:0]               out_op,
   output logic [15:0]              op_count
`ifdef LOGIC_OP_PIPE_REDUCE_EN
   ,
   output logic                     reduce_out
`endif
);

   state_e           state_q;
   state_e           state_d;
   logic             run_q;
   logic             accept;
   logic             drain;
   logic             load_head_new;
   logic             load_head_tail;
   logic             load_tail;
   op_e              op_sel;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] head_data;
   logic [2:0]       head_op;
   logic [WIDTH-1:0] tail_data;
   logic [2:0]       tail_op;

   assign op_sel = op_e'(in_op);

   logic_op_core #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_core (
      .data   (in_data),
      .op     (op_sel),
      .result (result)
   );

   // handshake flags come straight from registers so in_ready never depends on out_ready
   assign in_ready  = run_q && (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // state register; run_q keeps in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // next-state and store-load decisions for the head/tail pair
   always_comb begin
      state_d        = state_q;
      load_head_new  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d       = ST_ONE;
               load_head_new = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               load_head_new = 1'b1;
            end else if (accept) begin
               state_d   = ST_FULL;
               load_tail = 1'b1;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               state_d        = ST_ONE;
               load_head_tail = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // head entry is what the consumer sees; it only moves on a load, so it holds under back-pressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_data <= '0;
         head_op   <= '0;
      end else if (load_head_new) begin
         head_data <= result;
         head_op   <= in_op;
      end else if (load_head_tail) begin
         head_data <= tail_data;
         head_op   <= tail_op;
      end
   end

   // tail entry holds the second-oldest result while the head is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tail_data <= '0;
         tail_op   <= '0;
      end else if (load_tail) begin
         tail_data <= result;
         tail_op   <= in_op;
      end
   end

   // saturating count of accepted transactions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (accept && (op_count != 16'hFFFF)) begin
         op_count <= op_count + 16'd1;
      end
   end

   assign out_data = head_data;
   assign out_op   = head_op;

`ifdef LOGIC_OP_PIPE_REDUCE_EN
   assign reduce_out = ^head_data;
`endif

endmodule
